// File: rtl/encoder4to2_fifo.sv
// Registered 4-to-2 priority encoder: each new nonzero input pattern is encoded,
// tagged when several lines were active, and queued in a show-ahead FIFO drained by valid/ready.
module encoder4to2_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               d,
    input  logic                     ready,
    input  logic                     clr_ovf,
    output logic [1:0]               a,
    output logic                     valid,
    output logic                     multi,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Highest set line wins; an all-zero input never reaches this encoder.
    function automatic logic [1:0] enc_f(input logic [3:0] v);
        logic [1:0] code;
        if (v[3]) begin
            code = 2'b11;
        end else if (v[2]) begin
            code = 2'b10;
        end else if (v[1]) begin
            code = 2'b01;
        end else begin
            code = 2'b00;
        end
        return code;
    endfunction

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic multi_f(input logic [3:0] v);
        return ((v & (v - 4'd1)) != 4'b0000);
    endfunction

    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_d_q;
    logic          r_ovf;

    logic          w_event;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [2:0]    w_head;

    // Event detection and push/pop/drop arbitration.
    always_comb begin
        w_event = (d != 4'b0000) && (d != r_d_q);
        w_full  = (r_count == CNT_FULL);
        w_empty = (r_count == {CW{1'b0}});
        w_pop   = !w_empty && ready;
        w_push  = w_event && (!w_full || w_pop);
        w_drop  = w_event && w_full && !w_pop;
        w_head  = r_mem[r_rptr];
    end

    // Queue storage, pointers, occupancy, input history and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 3'b000;
            end
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_d_q   <= 4'b0000;
            r_ovf   <= 1'b0;
        end else begin
            r_d_q <= d;
            if (w_push) begin
                r_mem[r_wptr] <= {multi_f(d), enc_f(d)};
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    // Head decode from registers; forced to zero while the queue is empty.
    always_comb begin
        valid = 1'b0;
        a     = 2'b00;
        multi = 1'b0;
        count = r_count;
        ovf   = r_ovf;
        if (!w_empty) begin
            valid = 1'b1;
            a     = w_head[1:0];
            multi = w_head[2];
        end else begin
            valid = 1'b0;
            a     = 2'b00;
            multi = 1'b0;
        end
    end

endmodule
